// File: rtl/avalon_seg_display_ctrl.sv
// avalon_seg_display_ctrl: Avalon-MM slave driving active-low 7-segment digits with hex/raw modes, blank, blink and lamp test
module avalon_seg_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int ADDR_W     = 4,
   parameter int BLINK_W    = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_W-1:0]       avms_address_i,
   input  logic [3:0]              avms_byteenable_i,
   input  logic                    avms_write_i,
   input  logic [31:0]             avms_writedata_i,
   input  logic                    avms_read_i,
   output logic [31:0]             avms_readdata_o,
   output logic                    avms_readdatavalid_o,
   output logic [NUM_DIGITS*7-1:0] segment_o
);
   localparam int CTRL_A  = NUM_DIGITS;
   localparam int BLINK_A = NUM_DIGITS + 1;
   localparam logic [6:0] HEX_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [14:0]             digit_q [NUM_DIGITS];
   logic [14:0]             digit_d [NUM_DIGITS];
   logic [1:0]              ctrl_q, ctrl_d;
   logic [BLINK_W-1:0]      blink_q, blink_d, cnt_q, cnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;
   logic                    readdatavalid_q, readdatavalid_d;
   logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
   logic [31:0]             addr, be_m, rd_mux;
   logic                    wr_blink, last, unused_ok;
   always_comb begin
      addr = 32'(avms_address_i);
      be_m = {{8{avms_byteenable_i[3]}}, {8{avms_byteenable_i[2]}}, {8{avms_byteenable_i[1]}}, {8{avms_byteenable_i[0]}}};
      wr_blink = avms_write_i && addr == 32'(BLINK_A);
      for (int i = 0; i < NUM_DIGITS; i++)
         digit_d[i] = (avms_write_i && addr == 32'(i)) ?
            (digit_q[i] & ~be_m[14:0]) | (avms_writedata_i[14:0] & be_m[14:0] & 15'h7F7F) : digit_q[i];
      ctrl_d = (avms_write_i && addr == 32'(CTRL_A)) ?
         (ctrl_q & ~be_m[1:0]) | (avms_writedata_i[1:0] & be_m[1:0]) : ctrl_q;
      blink_d = wr_blink ?
         (blink_q & ~be_m[BLINK_W-1:0]) | (avms_writedata_i[BLINK_W-1:0] & be_m[BLINK_W-1:0]) : blink_q;
      // a BLINK write restarts the timebase in the visible phase
      last = cnt_q == blink_q - BLINK_W'(1);
      cnt_d = (wr_blink || blink_q == '0 || last) ? '0 : cnt_q + BLINK_W'(1);
      phase_d = (wr_blink || blink_q == '0) ? 1'b1 : phase_q ^ last;
      rd_mux = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (addr == 32'(i)) rd_mux = 32'(digit_q[i]);
      if (addr == 32'(CTRL_A)) rd_mux = 32'(ctrl_q);
      if (addr == 32'(BLINK_A)) rd_mux = 32'(blink_q);
      readdata_d = avms_read_i ? rd_mux : '0;
      readdatavalid_d = avms_read_i;
      seg_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         seg_d[7*i +: 7] = ctrl_q[1] ? 7'h00 :
            (!ctrl_q[0] || digit_q[i][5] || (digit_q[i][6] && !phase_q)) ? 7'h7F :
            digit_q[i][4] ? ~digit_q[i][14:8] : HEX_LUT[digit_q[i][3:0]];
      unused_ok = ^{avms_writedata_i, be_m};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
         ctrl_q          <= 2'b01;
         blink_q         <= '0;
         cnt_q           <= '0;
         phase_q         <= 1'b1;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         seg_q           <= {NUM_DIGITS{7'h40}};
      end else begin
         digit_q         <= digit_d;
         ctrl_q          <= ctrl_d;
         blink_q         <= blink_d;
         cnt_q           <= cnt_d;
         phase_q         <= phase_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         seg_q           <= seg_d;
      end
   end
   assign avms_readdata_o      = readdata_q;
   assign avms_readdatavalid_o = readdatavalid_q;
   assign segment_o            = seg_q;
endmodule

// File: tb/tb_avalon_seg_display_ctrl.sv
// tb_avalon_seg_display_ctrl: randomized scoreboard bench against a register-level reference model
module tb_avalon_seg_display_ctrl;
   localparam int ND = 6;
   localparam int AW = 4;
   localparam int BW = 24;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   avms_address_i = '0;
   logic [3:0]      avms_byteenable_i = '0;
   logic            avms_write_i = 1'b0;
   logic [31:0]     avms_writedata_i = '0;
   logic            avms_read_i = 1'b0;
   logic [31:0]     avms_readdata_o;
   logic            avms_readdatavalid_o;
   logic [ND*7-1:0] segment_o;
   avalon_seg_display_ctrl #(.NUM_DIGITS(ND), .ADDR_W(AW), .BLINK_W(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .avms_address_i(avms_address_i), .avms_byteenable_i(avms_byteenable_i),
      .avms_write_i(avms_write_i), .avms_writedata_i(avms_writedata_i),
      .avms_read_i(avms_read_i), .avms_readdata_o(avms_readdata_o),
      .avms_readdatavalid_o(avms_readdatavalid_o), .segment_o(segment_o)
   );
   always #5 clk = ~clk;
   logic [6:0]      hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [31:0]     m_dig [ND];
   logic [31:0]     m_ctrl, m_blink, m_cnt;
   bit              m_phase;
   logic [ND*7-1:0] exp_seg;
   bit              exp_valid;
   bit              armed = 1'b0;
   logic [31:0]     rq [$];
   int              checks = 0;
   int              failures = 0;
   function automatic logic [ND*7-1:0] model_seg();
      logic [ND*7-1:0] s;
      s = '0;
      for (int i = 0; i < ND; i++) begin
         if (m_ctrl[1]) s[7*i +: 7] = 7'h00;
         else if (!m_ctrl[0] || m_dig[i][5] || (m_dig[i][6] && !m_phase)) s[7*i +: 7] = 7'h7F;
         else if (m_dig[i][4]) s[7*i +: 7] = ~m_dig[i][14:8];
         else s[7*i +: 7] = hex_t[m_dig[i][3:0]];
      end
      return s;
   endfunction
   function automatic logic [31:0] model_rd(int a);
      if (a < ND) return m_dig[a];
      if (a == ND) return m_ctrl;
      if (a == ND + 1) return m_blink;
      return 32'h0;
   endfunction
   always @(posedge clk) begin
      int a;
      logic [31:0] v;
      a = int'(avms_address_i);
      if (!rst_n) begin
         for (int i = 0; i < ND; i++) m_dig[i] = 32'h0;
         m_ctrl = 32'h1;
         m_blink = 32'h0;
         m_cnt = 32'h0;
         m_phase = 1'b1;
         exp_valid = 1'b0;
         rq.delete();
         exp_seg = {ND{7'h40}};
         armed = 1'b1;
      end else begin
         exp_seg = model_seg();
         exp_valid = avms_read_i;
         if (avms_read_i) rq.push_back(model_rd(a));
         if (m_blink == 0) begin
            m_cnt = 0;
            m_phase = 1'b1;
         end else if (m_cnt == m_blink - 1) begin
            m_cnt = 0;
            m_phase = !m_phase;
         end else m_cnt = m_cnt + 1;
         if (avms_write_i) begin
            v = model_rd(a);
            for (int b = 0; b < 4; b++)
               if (avms_byteenable_i[b]) v[8*b +: 8] = avms_writedata_i[8*b +: 8];
            if (a < ND) m_dig[a] = v & 32'h7F7F;
            else if (a == ND) m_ctrl = v & 32'h3;
            else if (a == ND + 1) begin
               m_blink = v & ((32'h1 << BW) - 1);
               m_cnt = 0;
               m_phase = 1'b1;
            end
         end
      end
   end
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (armed) begin
         chk("segment", 64'(segment_o), 64'(exp_seg));
         chk("rvalid", 64'(avms_readdatavalid_o), 64'(exp_valid));
         if (avms_readdatavalid_o) begin
            if (rq.size() == 0) chk("rdq_empty", 64'(avms_readdata_o), 64'hDEAD_0000_0000_0000);
            else chk("rdata", 64'(avms_readdata_o), 64'(rq.pop_front()));
         end else chk("rdata_idle", 64'(avms_readdata_o), 64'h0);
      end
   end
   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr(int a, logic [31:0] d, logic [3:0] be);
      avms_address_i = AW'(a);
      avms_writedata_i = d;
      avms_byteenable_i = be;
      avms_write_i = 1'b1;
      idle(1);
      avms_write_i = 1'b0;
   endtask
   task automatic rd(int a);
      avms_address_i = AW'(a);
      avms_read_i = 1'b1;
      idle(1);
      avms_read_i = 1'b0;
   endtask
   task automatic rw(int a, logic [31:0] d);
      avms_address_i = AW'(a);
      avms_writedata_i = d;
      avms_byteenable_i = 4'hF;
      avms_write_i = 1'b1;
      avms_read_i = 1'b1;
      idle(1);
      avms_write_i = 1'b0;
      avms_read_i = 1'b0;
   endtask
   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(4);
      chk("reset_seg", 64'(segment_o), 64'({ND{7'h40}}));
      wr(2, 32'hA, 4'hF);
      idle(1);
      chk("dig2_hexA", 64'(segment_o[20:14]), 64'h08);
      rd(2);
      idle(2);
      wr(0, 32'h7F10, 4'h1);
      rd(0);
      idle(2);
      wr(0, 32'h7F10, 4'h2);
      rd(0);
      idle(2);
      wr(ND + 1, 32'd4, 4'hF);
      wr(1, 32'h45, 4'hF);
      idle(20);
      wr(ND + 1, 32'd0, 4'h4);
      idle(10);
      wr(ND, 32'h0, 4'hF);
      idle(1);
      chk("disabled", 64'(segment_o), 64'({ND{7'h7F}}));
      wr(ND, 32'h2, 4'hF);
      idle(1);
      chk("lamp_test", 64'(segment_o), 64'h0);
      wr(ND, 32'h1, 4'hF);
      rd(ND + 2);
      wr(ND + 2, 32'hFFFF_FFFF, 4'hF);
      for (int a = 0; a < 16; a++) rd(a);
      wr(3, 32'h3, 4'hF);
      rw(3, 32'h7);
      rd(3);
      idle(2);
      rd(2);
      rst_n = 1'b0;
      idle(1);
      avms_read_i = 1'b1;
      idle(1);
      avms_read_i = 1'b0;
      rst_n = 1'b1;
      idle(1);
      for (int a = 0; a < ND + 2; a++) rd(a);
      for (int n = 0; n < 600; n++) begin
         int op, a;
         logic [31:0] d;
         op = $urandom_range(0, 3);
         a = $urandom_range(0, 15);
         d = (a == ND + 1) ? 32'($urandom_range(0, 5)) : $urandom;
         if (op == 0) wr(a, d, 4'($urandom_range(0, 15)));
         else if (op == 1) rd(a);
         else if (op == 2) rw(a, d);
         else idle($urandom_range(1, 6));
      end
      idle(5);
      chk("rq_drain", 64'(rq.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
